// File: rtl/panda_pkg.sv
// Shared Panda types: memory access sizes, LSU FSM states and small address helpers.
package panda_pkg;

    typedef enum logic [1:0] {
        MemByte = 2'b00,
        MemHalf = 2'b01,
        MemWord = 2'b10
    } mem_size_e;

    typedef enum logic {
        LsuIdle,
        LsuResp
    } lsu_state_e;

    // Encoding 2'b11 is treated as a word access.
    function automatic mem_size_e decode_size(input logic [1:0] size);
        case (size)
            2'b00:   return MemByte;
            2'b01:   return MemHalf;
            default: return MemWord;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            MemHalf: return off[0];
            MemWord: return |off;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_off(input mem_size_e size, input logic [1:0] off);
        case (size)
            MemHalf: return {off[1], 1'b0};
            MemWord: return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/panda_lsu_load_align.sv
// Extracts the addressed byte/half/word lane from a RAM word and sign- or zero-extends it.
module panda_lsu_load_align
    import panda_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;

    always_comb begin
        lane   = rdata_i >> {off_i, 3'b000};
        data_o = lane;
        case (size_i)
            MemByte: data_o = {{24{~unsigned_i & lane[7]}}, lane[7:0]};
            MemHalf: data_o = {{16{~unsigned_i & lane[15]}}, lane[15:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/panda_lsu.sv
// Panda load/store unit: one outstanding access, 1-cycle RAM latency, stalls under back-pressure.
// Define PANDA_LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses instead of aligning.
module panda_lsu
    import panda_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned Depth     = 1024,
    localparam int unsigned RamAw    = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 ram_ce_o,
    output logic [3:0]           ram_we_o,
    output logic [RamAw-1:0]     ram_addr_o,
    output logic [31:0]          ram_wdata_o,
    input  logic [31:0]          ram_rdata_i
);

    lsu_state_e  state_q;
    logic        we_q;
    mem_size_e   size_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic        err_q;

    mem_size_e   req_size;
    logic [1:0]  req_off;
    logic        req_err;
    logic        req_accept;
    logic        ram_access;
    logic [31:0] load_data;

    // High address bits above the RAM are ignored, so accesses wrap.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[AddrWidth-1:2+RamAw];

    assign req_size = decode_size(req_size_i);

`ifdef PANDA_LSU_MISALIGN_TRAP_EN
    assign req_err   = misaligned(req_size, req_addr_i[1:0]);
    assign req_off   = req_addr_i[1:0];
    assign rsp_err_o = rsp_valid_o & err_q;
`else
    assign req_err   = 1'b0;
    assign req_off   = align_off(req_size, req_addr_i[1:0]);
    assign rsp_err_o = 1'b0;
`endif

    assign rsp_valid_o = (state_q == LsuResp);
    assign req_ready_o = (state_q == LsuIdle) | (rsp_valid_o & rsp_ready_i);
    assign req_accept  = req_valid_i & req_ready_o;
    assign ram_access  = req_accept & ~req_err;

    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (ram_access) begin
            ram_ce_o   = 1'b1;
            ram_addr_o = req_addr_i[2 +: RamAw];
            if (req_we_i) begin
                unique case (req_size)
                    MemByte: begin
                        ram_we_o    = 4'b0001 << req_off;
                        ram_wdata_o = {4{req_wdata_i[7:0]}};
                    end
                    MemHalf: begin
                        ram_we_o    = 4'b0011 << req_off;
                        ram_wdata_o = {2{req_wdata_i[15:0]}};
                    end
                    default: begin
                        ram_we_o    = 4'b1111;
                        ram_wdata_o = req_wdata_i;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LsuIdle;
            we_q       <= 1'b0;
            size_q     <= MemByte;
            unsigned_q <= 1'b0;
            off_q      <= 2'b00;
            err_q      <= 1'b0;
        end else if (req_accept) begin
            state_q    <= LsuResp;
            we_q       <= req_we_i;
            size_q     <= req_size;
            unsigned_q <= req_unsigned_i;
            off_q      <= req_off;
            err_q      <= req_err;
        end else if (rsp_valid_o && rsp_ready_i) begin
            state_q    <= LsuIdle;
        end
    end

    panda_lsu_load_align u_load_align (
        .rdata_i    (ram_rdata_i),
        .size_i     (size_q),
        .off_i      (off_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_data)
    );

    // The RAM holds its output while idle, so this stays stable under back-pressure.
    assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_panda_lsu.sv
// Directed bench for panda_lsu with a byte-writable RAM model (1-cycle read latency).
module tb_panda_lsu;

    localparam int unsigned Depth = 1024;
    localparam int unsigned RamAw = $clog2(Depth);

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_we_i;
    logic [1:0]       req_size_i;
    logic             req_unsigned_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_wdata_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_rdata_o;
    logic             rsp_err_o;
    logic             ram_ce_o;
    logic [3:0]       ram_we_o;
    logic [RamAw-1:0] ram_addr_o;
    logic [31:0]      ram_wdata_o;
    logic [31:0]      ram_rdata_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [Depth];

    always #5 clk_i = ~clk_i;

    panda_lsu #(
        .AddrWidth (32),
        .Depth     (Depth)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .ram_ce_o       (ram_ce_o),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    initial begin
        for (int i = 0; i < Depth; i++) mem[i] = 32'h0;
        ram_rdata_i = 32'h0;
    end

    // Read-first RAM: output changes only on an enabled cycle.
    always @(posedge clk_i) begin
        if (ram_ce_o) begin
            ram_rdata_i <= mem[ram_addr_o];
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid_i    = v;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = a;
        req_wdata_i    = wd;
    endtask

    initial begin
        rst_ni      = 1'b0;
        rsp_ready_i = 1'b1;
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        check("rst_ram_ce", ram_ce_o, 0);
        check("rst_ram_we", ram_we_o, 0);
        check("rst_ram_addr", ram_addr_o, 0);
        check("rst_ram_wdata", ram_wdata_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Word store 0xDEADBEEF to 0x10
        @(negedge clk_i);
        drive(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        #1;
        check("sw_ce", ram_ce_o, 1);
        check("sw_we", ram_we_o, 4'b1111);
        check("sw_addr", ram_addr_o, 4);
        check("sw_wdata", ram_wdata_o, 32'hDEADBEEF);

        // Word load 0x10, back-to-back with store response
        @(negedge clk_i);
        check("sw_rsp_valid", rsp_valid_o, 1);
        check("sw_rsp_rdata", rsp_rdata_o, 0);
        drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
        #1;
        check("lw_ce", ram_ce_o, 1);
        check("lw_we", ram_we_o, 0);
        check("lw_addr", ram_addr_o, 4);

        @(negedge clk_i);
        check("lw_rdata", rsp_rdata_o, 32'hDEADBEEF);
        check("lw_err", rsp_err_o, 0);
        drive(1, 1, 2'b00, 0, 32'h13, 32'h000000A5);
        #1;
        check("sb_we", ram_we_o, 4'b1000);
        check("sb_wdata", ram_wdata_o, 32'hA5A5A5A5);

        @(negedge clk_i);
        drive(1, 0, 2'b00, 0, 32'h13, 32'h0);
        @(negedge clk_i);
        check("lb_signed", rsp_rdata_o, 32'hFFFFFFA5);
        drive(1, 0, 2'b00, 1, 32'h13, 32'h0);
        @(negedge clk_i);
        check("lbu", rsp_rdata_o, 32'h000000A5);
        drive(1, 1, 2'b10, 0, 32'h10, 32'h80010000);

        @(negedge clk_i);
        drive(1, 0, 2'b01, 0, 32'h12, 32'h0);
        @(negedge clk_i);
        check("lh_signed", rsp_rdata_o, 32'hFFFF8001);
        drive(1, 0, 2'b01, 1, 32'h12, 32'h0);
        @(negedge clk_i);
        check("lhu", rsp_rdata_o, 32'h00008001);

        // Back-to-back loads, one response per cycle
        drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
        #1;
        check("b2b_ready0", req_ready_o, 1);
        @(negedge clk_i);
        check("b2b_lw", rsp_rdata_o, 32'h80010000);
        check("b2b_valid1", rsp_valid_o, 1);
        drive(1, 0, 2'b00, 1, 32'h13, 32'h0);
        #1;
        check("b2b_ready1", req_ready_o, 1);
        @(negedge clk_i);
        check("b2b_lbu13", rsp_rdata_o, 32'h00000080);
        drive(1, 0, 2'b00, 1, 32'h12, 32'h0);
        #1;
        check("b2b_ready2", req_ready_o, 1);
        @(negedge clk_i);
        check("b2b_lbu12", rsp_rdata_o, 32'h00000001);

        // Back-pressure for 3 cycles with a pending new request
        rsp_ready_i = 1'b0;
        drive(1, 0, 2'b00, 0, 32'h13, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", req_ready_o, 0);
            check("bp_ce", ram_ce_o, 0);
            check("bp_valid", rsp_valid_o, 1);
            check("bp_rdata", rsp_rdata_o, 32'h00000001);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        #1;
        check("bp_release_ready", req_ready_o, 1);
        check("bp_release_ce", ram_ce_o, 1);
        @(negedge clk_i);
        check("bp_next_lb", rsp_rdata_o, 32'hFFFFFF80);

        // Misaligned word load from 0x6
        drive(1, 0, 2'b10, 0, 32'h6, 32'h0);
        #1;
`ifdef PANDA_LSU_MISALIGN_TRAP_EN
        check("mis_ce", ram_ce_o, 0);
        @(negedge clk_i);
        check("mis_valid", rsp_valid_o, 1);
        check("mis_err", rsp_err_o, 1);
        check("mis_rdata", rsp_rdata_o, 0);
`else
        check("mis_ce", ram_ce_o, 1);
        check("mis_addr", ram_addr_o, 1);
        @(negedge clk_i);
        check("mis_valid", rsp_valid_o, 1);
        check("mis_err", rsp_err_o, 0);
        check("mis_rdata", rsp_rdata_o, 0);
`endif

        // Reset while a response is pending
        drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
        @(negedge clk_i);
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        rsp_ready_i = 1'b0;
        check("mid_valid_pre", rsp_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid_valid_rst", rsp_valid_o, 0);
        check("mid_ready_rst", req_ready_o, 1);
        check("mid_rdata_rst", rsp_rdata_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_ready", req_ready_o, 1);
        check("post_rst_valid", rsp_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/panda_lsu.md
# panda_lsu

Load/store unit between the Panda core's memory stage and the byte-writable data RAM. Accepts one load or store request at a time over a valid/ready handshake, drives the RAM chip-enable, byte-write-enables, word address and write data, then returns aligned, sign- or zero-extended load data over a valid/ready response channel. Handles the RAM's one-cycle read latency and holds results under response back-pressure.

## Interface
- `AddrWidth`, 32: byte-address width from the core.
- `Depth`, 1024: RAM depth in 32-bit words; RAM address width is `$clog2(Depth)`.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when both valid and ready are high.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned_i` in 1: zero-extend load, else sign-extend.
- `req_addr_i` in AddrWidth: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed when both valid and ready are high.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `rsp_err_o` out 1: misaligned access; see Configuration.
- `ram_ce_o` out 1: RAM chip enable.
- `ram_we_o` out 4: RAM byte write enables.
- `ram_addr_o` out `$clog2(Depth)`: word address, equal to `req_addr_i[2 +: $clog2(Depth)]`. Upper address bits are ignored, so accesses wrap.
- `ram_wdata_o` out 32: lane-replicated store data.
- `ram_rdata_i` in 32: RAM read data. It is valid one cycle after `ram_ce_o` and is held stable while `ram_ce_o` is low.

## Operation
- States: IDLE, RESP.
  - IDLE to RESP on request acceptance.
  - RESP to IDLE on response handshake with no new request.
  - RESP to RESP on response handshake together with a new acceptance.
- `req_ready_o` = (state == IDLE) | (rsp_valid_o & rsp_ready_i). This gives throughput of one access per cycle.
- On acceptance, `ram_ce_o`, `ram_we_o`, `ram_addr_o` and `ram_wdata_o` are driven combinationally from the request in the same cycle. Otherwise `ram_ce_o` = 0 and `ram_we_o` = 0.
- Byte enables, with off = addr[1:0]:
  - byte: 0001<<off
  - half: 0011<<off
  - word: 1111
  - loads: 0000
- Store data lane replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- On acceptance, the following are registered as pending: we, size, unsigned, off, err.
- In RESP:
  - `rsp_valid_o` = 1.
  - `rsp_rdata_o` is formed combinationally from the held `ram_rdata_i`. Extract the lane at 8*off, then sign- or zero-extend to 32 bits.
  - For stores or errors, `rsp_rdata_o` = 0.
- Reset values: state IDLE, `rsp_valid_o` 0, `rsp_err_o` 0, `rsp_rdata_o` 0, `req_ready_o` 1 (IDLE), all RAM outputs 0.
- Reset mid-operation: the pending response is dropped. A store whose `ram_ce_o` pulse already occurred remains committed, because the RAM has no reset.

## Timing
- Request accepted in cycle N gives RAM access in cycle N and `rsp_valid_o` in cycle N+1. Load-to-use latency is 1.
- A response held under `rsp_ready_i` = 0 keeps `rsp_rdata_o` stable. No RAM access occurs while blocked, so `ram_rdata_i` does not change.
- Back-to-back requests: the response handshake and the next acceptance fall in the same cycle. The new response appears the following cycle.
- There is a combinational path `rsp_ready_i` → `req_ready_o` → `ram_ce_o`. This is permitted, and the core's memory stage must register its side.

## Configuration
- `PANDA_LSU_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0] ≠ 0, or a word access with addr[1:0] ≠ 0, is accepted without a RAM access (`ram_ce_o` = 0).
  - Its response arrives at N+1 with `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
- `PANDA_LSU_MISALIGN_TRAP_EN` undefined:
  - Offset bits below the access size are forced to 0 (half clears addr[0], word clears addr[1:0]).
  - `rsp_err_o` is tied to 0.

## Structure
- The shared `panda_pkg` holds `mem_size_e` (MemByte, MemHalf, MemWord) and `lsu_state_e` (LsuIdle, LsuResp).
- One combinational sub-module, `panda_lsu_load_align`, takes rdata, size, offset and unsigned, and produces the extended data. The top level holds the FSM, pending registers and store formatting.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10: `ram_we_o` = 1111, `ram_addr_o` = 4. The load response at N+1 returns 0xDEADBEEF.
- Byte store 0xA5 to 0x13: `ram_we_o` = 1000, `ram_wdata_o` = 0xA5A5A5A5.
  - Byte load from 0x13 returns 0xFFFFFFA5.
  - Unsigned byte load from 0x13 returns 0x000000A5.
- Half load from 0x12 of word 0x80010000: signed returns 0xFFFF8001; unsigned returns 0x00008001.
- Back-to-back loads with `rsp_ready_i` held high: one response per cycle and `req_ready_o` stays 1. Then hold `rsp_ready_i` low for 3 cycles: `rsp_rdata_o` stays stable, `req_ready_o` = 0 and `ram_ce_o` = 0.
- Word load from 0x6:
  - With the macro: no `ram_ce_o`, and the response has `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
  - Without the macro: `ram_addr_o` = 1 and `rsp_err_o` = 0.
- Assert `rst_ni` low while in RESP: `rsp_valid_o` drops to 0 immediately, and after release the FSM is in IDLE with `req_ready_o` = 1.
